// File: rtl/epsilon_greedy_policy.sv
// Epsilon-greedy action selector: sequential signed argmax over latched Q-values,
// with an LFSR coin flip that can replace the greedy choice by a random action.
module epsilon_greedy_policy #(
  parameter int unsigned NUM_ACTIONS = 4,
  parameter int unsigned Q_WIDTH     = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic [15:0]                    epsilon_i,
  input  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_values_i,
  output logic [NUM_ACTIONS-1:0]         action_o,
  output logic                           action_valid_o,
  output logic                           explored_o,
  output logic                           busy_o
);

  localparam int unsigned IDX_W     = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;
  localparam int unsigned QV_W      = NUM_ACTIONS * Q_WIDTH;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DECIDE
  } state_e;

  state_e                      state_q, state_d;
  logic [15:0]                 lfsr_q, lfsr_d;
  logic [QV_W-1:0]             q_reg_q, q_reg_d;
  logic [15:0]                 eps_q, eps_d;
  logic [15:0]                 rnd_q, rnd_d;
  logic signed [Q_WIDTH-1:0]   best_q_q, best_q_d;
  logic [IDX_W-1:0]            best_idx_q, best_idx_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_ACTIONS-1:0]      action_q, action_d;
  logic                        valid_q, valid_d;
  logic                        explored_q, explored_d;
  logic                        busy_q, busy_d;

  logic signed [Q_WIDTH-1:0]   q_cur_c;
  logic                        explore_c;
  logic [IDX_W-1:0]            sel_c;

  assign q_cur_c = $signed(q_reg_q[idx_q*Q_WIDTH +: Q_WIDTH]);

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    q_reg_d    = q_reg_q;
    eps_d      = eps_q;
    rnd_d      = rnd_q;
    best_q_d   = best_q_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    action_d   = action_q;
    valid_d    = 1'b0;
    explored_d = explored_q;
    busy_d     = busy_q;
    explore_c  = 1'b0;
    sel_c      = '0;
    // Galois form, shifting right; runs regardless of FSM state
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          q_reg_d = q_values_i;
          eps_d   = epsilon_i;
          rnd_d   = lfsr_q;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties
        if ((idx_q == '0) || (q_cur_c > best_q_q)) begin
          best_q_d   = q_cur_c;
          best_idx_d = idx_q;
        end
        if (idx_q == IDX_W'(NUM_ACTIONS - 1)) begin
          state_d = S_DECIDE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DECIDE: begin
        explore_c  = (rnd_q < eps_q);
        sel_c      = explore_c ? lfsr_q[IDX_W-1:0] : best_idx_q;
        action_d   = NUM_ACTIONS'(1) << sel_c;
        explored_d = explore_c;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      q_reg_q    <= '0;
      eps_q      <= '0;
      rnd_q      <= '0;
      best_q_q   <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      action_q   <= '0;
      valid_q    <= 1'b0;
      explored_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      q_reg_q    <= q_reg_d;
      eps_q      <= eps_d;
      rnd_q      <= rnd_d;
      best_q_q   <= best_q_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      action_q   <= action_d;
      valid_q    <= valid_d;
      explored_q <= explored_d;
      busy_q     <= busy_d;
    end
  end

  assign action_o       = action_q;
  assign action_valid_o = valid_q;
  assign explored_o     = explored_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_epsilon_greedy_policy.sv
// Bench for epsilon_greedy_policy: decision-level reference model compared every cycle,
// plus directed decisions with literal expectations.
module tb_epsilon_greedy_policy;

  localparam int unsigned NA = 4;
  localparam int unsigned QW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   epsilon;
  logic [63:0]   q_values;
  logic [3:0]    action;
  logic          action_valid;
  logic          explored;
  logic          busy;

  int checks = 0;
  int errors = 0;

  epsilon_greedy_policy #(.NUM_ACTIONS(NA), .Q_WIDTH(QW), .LFSR_SEED(16'hACE1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .epsilon_i     (epsilon),
    .q_values_i    (q_values),
    .action_o      (action),
    .action_valid_o(action_valid),
    .explored_o    (explored),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic signed [15:0] qv(input logic [63:0] q, input int i);
    return $signed(q[i*16 +: 16]);
  endfunction

  function automatic logic [63:0] pack4(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Decision-level model: whole decision resolved at acceptance, delivered after a countdown
  logic [15:0] m_lfsr;
  int          m_busy_cnt;
  logic        m_valid;
  logic [3:0]  m_action;
  logic        m_explored;
  logic [3:0]  p_action;
  logic        p_explored;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr     = 16'hACE1;
      m_busy_cnt = 0;
      m_valid    = 1'b0;
      m_action   = '0;
      m_explored = 1'b0;
      p_action   = '0;
      p_explored = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          m_valid    = 1'b1;
          m_action   = p_action;
          m_explored = p_explored;
        end
      end else if (start) begin
        int best;
        logic [15:0] lf;
        best = 0;
        for (int i = 1; i < NA; i++)
          if (qv(q_values, i) > qv(q_values, best)) best = i;
        lf = m_lfsr;
        for (int k = 0; k < NA + 1; k++) lf = lfsr_step(lf);
        p_explored = (m_lfsr < epsilon);
        p_action   = 4'b0001 << (p_explored ? int'(lf[1:0]) : best);
        m_busy_cnt = NA + 1;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_valid", 32'(action_valid), 32'(m_valid));
    chk("cyc_action", 32'(action), 32'(m_action));
    chk("cyc_explored", 32'(explored), 32'(m_explored));
    chk("cyc_busy", 32'(busy), 32'(m_busy_cnt != 0));
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_action", 32'(action), 0);
    chk("rst_valid", 32'(action_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_explored", 32'(explored), 0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated decision; checks latency, busy length and (optionally) the action
  task automatic decide_one(input string name, input logic [15:0] eps, input logic [63:0] q,
                            input bit check_act, input logic [3:0] exp_act, input logic exp_expl);
    int n;
    int nb;
    @(negedge clk);
    start = 1'b1; epsilon = eps; q_values = q;
    @(negedge clk);
    start = 1'b0; n = 1; nb = 0;
    while (!action_valid && n < 20) begin
      nb += int'(busy);
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 6);
    chk({name, "_busy_len"}, 32'(nb), 5);
    if (check_act) chk({name, "_action"}, 32'(action), 32'(exp_act));
    chk({name, "_explored"}, 32'(explored), 32'(exp_expl));
    @(negedge clk);
    chk({name, "_valid_pulse"}, 32'(action_valid), 0);
  endtask

  // Hold start high with random Q-values until n decisions are delivered
  task automatic run_stream(input string name, input logic [15:0] eps, input int n,
                            output int n_expl);
    int got;
    int cyc;
    got = 0; cyc = 0; n_expl = 0;
    epsilon = eps;
    while (got < n && cyc < n * 6 + 50) begin
      @(negedge clk);
      if (action_valid) begin
        got++;
        n_expl += int'(explored);
      end
      start = 1'b1;
      q_values = {$urandom(), $urandom()};
      cyc++;
    end
    chk({name, "_count"}, 32'(got), 32'(n));
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n;
    int n_expl;
    rst_n = 1'b0; start = 1'b0; epsilon = '0; q_values = '0;
    chk("model_lfsr_step", 32'(lfsr_step(16'hACE1)), 32'h0000E270);
    do_reset();

    // Greedy pick of a2
    decide_one("greedy", 16'h0000, pack4(16'd10, 16'hFFFB, 16'd300, 16'd299), 1'b1, 4'b0100, 1'b0);
    // Tie on max positive, lowest index wins; then all minimum values
    decide_one("tie_max", 16'h0000, pack4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000), 1'b1, 4'b0001, 1'b0);
    decide_one("all_min", 16'h0000, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 1'b1, 4'b0001, 1'b0);
    decide_one("neg_pick", 16'h0000, pack4(16'h8000, 16'hFFFF, 16'h8001, 16'hFFFE), 1'b1, 4'b0010, 1'b0);

    // Forced exploration shortly after reset, then a long scoreboarded stream
    do_reset();
    repeat (2) @(negedge clk);
    decide_one("explore", 16'hFFFF, pack4(16'd1, 16'd2, 16'd3, 16'd4), 1'b0, 4'b0000, 1'b1);
    run_stream("explore_stream", 16'hFFFF, 1000, n_expl);

    // Start held during scan: first inputs win, back-to-back second decision uses new inputs
    @(negedge clk);
    start = 1'b1; epsilon = 16'h0000; q_values = pack4(16'd1, 16'd50, 16'd2, 16'd3);
    @(negedge clk);
    q_values = pack4(16'd1, 16'd2, 16'd3, 16'd90);
    n = 1;
    while (!action_valid && n < 20) begin @(negedge clk); n++; end
    chk("held_first_latency", 32'(n), 6);
    chk("held_first_action", 32'(action), 32'(4'b0010));
    @(negedge clk);
    chk("held_single_pulse", 32'(action_valid), 0);
    n = 1;
    while (!action_valid && n < 20) begin @(negedge clk); n++; end
    start = 1'b0;
    chk("held_second_period", 32'(n), 6);
    chk("held_second_action", 32'(action), 32'(4'b1000));
    repeat (8) @(negedge clk);

    // Reset during the third scan cycle aborts without a result
    @(negedge clk);
    start = 1'b1; epsilon = 16'h0000; q_values = pack4(16'd7, 16'd1, 16'd1, 16'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_action", 32'(action), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(action_valid), 0);
    chk("abort_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin @(negedge clk); n += int'(action_valid); end
    chk("abort_no_pulse", 32'(n), 0);
    decide_one("after_abort", 16'h0000, pack4(16'd10, 16'hFFFB, 16'd300, 16'd299), 1'b1, 4'b0100, 1'b0);

    // Statistical exploration rate at epsilon = 0.25
    run_stream("stat_stream", 16'h4000, 4096, n_expl);
    chk("stat_fraction_in_range", 32'((n_expl >= 901) && (n_expl <= 1147)), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
